lc3_mem_ctrl: RTL

//  Memory access unit between the LC-3 control FSM (MAR/MDR, MIO.EN, R.W) and the block RAM.

---
 rtl/lc3_pkg.sv | 24 ++
 rtl/lc3_mem_ctrl_if.sv | 23 ++
 rtl/lc3_kbd_regs.sv | 26 ++
 rtl/lc3_mem_ctrl.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/lc3_pkg.sv
// Shared LC-3 memory-map constants and the memory-controller state encoding.
// Latency: none (declarations only); backpressure: n/a.
package lc3_pkg;

    localparam logic [15:0] KBSR_ADDR = 16'hFE00;
    localparam logic [15:0] KBDR_ADDR = 16'hFE02;
    localparam logic [15:0] DSR_ADDR  = 16'hFE04;
    localparam logic [15:0] DDR_ADDR  = 16'hFE06;
    localparam logic [6:0]  DEV_PAGE  = 7'h7F;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RAM_ACC,
        ST_DEV_ACC,
        ST_UNMAP,
        ST_DONE,
        ST_RECOVER
    } mem_state_e;

    function automatic logic is_dev_page(input logic [15:0] addr);
        return addr[15:9] == DEV_PAGE;
    endfunction

endpackage

// File: rtl/lc3_mem_ctrl_if.sv
// RAM-side bus between the memory controller (master) and the block RAM (slave).
// Latency: wires only; backpressure: RAM holds off via i_mem_ready.
interface lc3_mem_ctrl_if #(
    parameter int ADDR_BITS = 9,
    parameter int WORD_BITS = 16
);
    logic                 o_mem_read_en;
    logic                 o_mem_write_en;
    logic [ADDR_BITS-1:0] o_mem_addr;
    logic [WORD_BITS-1:0] o_mem_wdata;
    logic                 i_mem_ready;
    logic [WORD_BITS-1:0] i_mem_rdata;

    modport master (
        output o_mem_read_en, o_mem_write_en, o_mem_addr, o_mem_wdata,
        input  i_mem_ready, i_mem_rdata
    );

    modport slave (
        input  o_mem_read_en, o_mem_write_en, o_mem_addr, o_mem_wdata,
        output i_mem_ready, i_mem_rdata
    );
endinterface

// File: rtl/lc3_kbd_regs.sv
// Keyboard status/data registers: a strobe latches the char and sets ready, a KBDR read clears it.
// Latency: 1 cycle from strobe to register; backpressure: none (new chars overwrite).
module lc3_kbd_regs (
    input  logic       i_CLK,
    input  logic       i_RST_N,
    input  logic       i_kb_valid,
    input  logic [7:0] i_kb_char,
    input  logic       kbdr_rd,
    output logic       kbsr_rdy,
    output logic [7:0] kbdr_dat
);

    // A char arriving on the same cycle as a KBDR read keeps ready set.
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            kbsr_rdy <= 1'b0;
            kbdr_dat <= 8'h00;
        end else if (i_kb_valid) begin
            kbsr_rdy <= 1'b1;
            kbdr_dat <= i_kb_char;
        end else if (kbdr_rd) begin
            kbsr_rdy <= 1'b0;
        end
    end

endmodule

// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory access unit: decodes MAR to RAM / device registers / unmapped and returns one ack.
// Latency: RAM 2+RAM-latency cycles, devices 2 cycles; backpressure: RAM stalls via ready, timeout errors.
module lc3_mem_ctrl
    import lc3_pkg::*;
#(
    parameter int ADDR_BITS = 9,
    parameter int WORD_BITS = 16,
    parameter int TIMEOUT   = 15
) (
    input  logic                 i_CLK,
    input  logic                 i_RST_N,
    input  logic                 i_req,
    input  logic                 i_rw,
    input  logic [15:0]          i_addr,
    input  logic [WORD_BITS-1:0] i_wdata,
    output logic                 o_ack,
    output logic                 o_err,
    output logic [WORD_BITS-1:0] o_rdata,
    lc3_mem_ctrl_if.master       mem,
    input  logic                 i_kb_valid,
    input  logic [7:0]           i_kb_char,
    input  logic                 i_dsp_ready,
    output logic                 o_dsp_valid,
    output logic [7:0]           o_dsp_char
);

    localparam logic [7:0] TMO_MAX = 8'(TIMEOUT);

    mem_state_e           state_q, state_d;
    logic [15:0]          addr_q;
    logic [WORD_BITS-1:0] wdata_q;
    logic                 rw_q;
    logic [WORD_BITS-1:0] rdata_q, rdata_d;
    logic                 err_q, err_d;
    logic [7:0]           tmo_q, tmo_d;
    logic                 kbdr_rd;
    logic                 dsp_vld;
    logic                 kbsr_rdy;
    logic [7:0]           kbdr_dat;
    logic                 ram_en_live;

    lc3_kbd_regs u_kbd_regs (
        .i_CLK      (i_CLK),
        .i_RST_N    (i_RST_N),
        .i_kb_valid (i_kb_valid),
        .i_kb_char  (i_kb_char),
        .kbdr_rd    (kbdr_rd),
        .kbsr_rdy   (kbsr_rdy),
        .kbdr_dat   (kbdr_dat)
    );

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rw_q    <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
            if (state_q == ST_IDLE && i_req) begin
                addr_q  <= i_addr;
                wdata_q <= i_wdata;
                rw_q    <= i_rw;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        tmo_d   = tmo_q;
        kbdr_rd = 1'b0;
        dsp_vld = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tmo_d = '0;
                if (i_req) begin
                    err_d = 1'b0;
                    if ((i_addr >> ADDR_BITS) == 16'h0) state_d = ST_RAM_ACC;
                    else if (is_dev_page(i_addr))       state_d = ST_DEV_ACC;
                    else                                state_d = ST_UNMAP;
                end
            end
            ST_RAM_ACC: begin
                // Once the counter hits the limit the enable is already down, so ready is ignored.
                if (tmo_q == TMO_MAX) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else if (mem.i_mem_ready) begin
                    state_d = ST_DONE;
                    if (!rw_q) rdata_d = mem.i_mem_rdata;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            ST_DEV_ACC: begin
                state_d = ST_DONE;
                if (!rw_q) begin
                    case (addr_q)
                        KBSR_ADDR: rdata_d = WORD_BITS'({kbsr_rdy, 15'b0});
                        KBDR_ADDR: begin
                            rdata_d = WORD_BITS'({8'b0, kbdr_dat});
                            kbdr_rd = 1'b1;
                        end
                        DSR_ADDR:  rdata_d = WORD_BITS'({i_dsp_ready, 15'b0});
                        default:   rdata_d = '0;
                    endcase
                end else if (addr_q == DDR_ADDR && i_dsp_ready) begin
                    dsp_vld = 1'b1;
                end
            end
            ST_UNMAP: begin
                state_d = ST_DONE;
                if (!rw_q) rdata_d = '0;
            end
            ST_DONE:    state_d = ST_RECOVER;
            ST_RECOVER: if (!mem.i_mem_ready) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Enables decode straight from state so an async reset kills them immediately.
    assign ram_en_live        = (state_q == ST_RAM_ACC) && (tmo_q != TMO_MAX);
    assign mem.o_mem_read_en  = ram_en_live && !rw_q;
    assign mem.o_mem_write_en = ram_en_live && rw_q;
    assign mem.o_mem_addr     = addr_q[ADDR_BITS-1:0];
    assign mem.o_mem_wdata    = wdata_q;

    assign o_ack       = (state_q == ST_DONE);
    assign o_err       = o_ack && err_q;
    assign o_rdata     = rdata_q;
    assign o_dsp_valid = dsp_vld;
    assign o_dsp_char  = wdata_q[7:0];

endmodule
